// File: rtl/ram_port_arbiter.sv
// Shares the SDRAM controller's toggle-handshake port between the Oric CPU/video RAM bus
// and a loader byte stream; CPU accesses win ties, one transaction in flight at a time.
module ram_port_arbiter #(
  parameter int AW          = 16,
  parameter int PROTECT_TOP = 1,
  parameter int TIMEOUT     = 63
) (
  input  logic          clk_sys,
  input  logic          res_n,
  input  logic          cpu_cs,
  input  logic          cpu_oe,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_busy,
  input  logic          ld_wr,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  output logic          ld_busy,
  output logic          ld_ovf,
  output logic          sd_req,
  input  logic          sd_ack,
  output logic [AW-1:0] sd_addr,
  output logic          sd_we,
  output logic [1:0]    sd_ds,
  output logic [15:0]   sd_d,
  input  logic [15:0]   sd_q,
  output logic          arb_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_LD   = 2'd2
  } state_t;

  state_t state, state_next;

  // Handshake: a transaction is issued by inverting sd_req together with the sd_* payload;
  // the controller finishes it by making sd_ack equal to sd_req, sd_q being valid from then.
  // The port is free only while sd_ack == sd_req, so nothing issues during a mismatch.
  logic port_idle;
  assign port_idle = (sd_ack == sd_req);

  logic          cpu_rd, cpu_wr, rd_d, wr_d;
  logic [AW-1:0] addr_d;
  logic          prot_hit, cpu_event;

  assign cpu_rd   = cpu_cs & cpu_oe;
  assign cpu_wr   = cpu_cs & cpu_we;
  assign prot_hit = (PROTECT_TOP != 0) && (cpu_addr[AW-1 -: 2] == 2'b11);
  assign cpu_event = !prot_hit &&
                     ((cpu_rd && !rd_d) || (cpu_wr && !wr_d) ||
                      (cpu_rd && (cpu_addr != addr_d)));

  logic          cpu_pend, pend_we;
  logic [AW-1:0] pend_addr;
  logic [7:0]    pend_din;
  logic [AW-1:0] hold_addr;
  logic [7:0]    hold_data;
  logic [CW-1:0] wait_cnt;

  logic issue_cpu, issue_ld, done;

  assign cpu_busy = cpu_pend | (state == ST_CPU);

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue_cpu  = 1'b0;
    issue_ld   = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (port_idle && cpu_pend) begin
          issue_cpu  = 1'b1;
          state_next = ST_CPU;
        end else if (port_idle && ld_busy) begin
          issue_ld   = 1'b1;
          state_next = ST_LD;
        end
      end
      ST_CPU, ST_LD: begin
        if (port_idle) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      rd_d      <= 1'b0;
      wr_d      <= 1'b0;
      addr_d    <= '0;
      cpu_pend  <= 1'b0;
      pend_we   <= 1'b0;
      pend_addr <= '0;
      pend_din  <= '0;
      ld_busy   <= 1'b0;
      ld_ovf    <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
      sd_req    <= 1'b0;
      sd_addr   <= '0;
      sd_we     <= 1'b0;
      sd_ds     <= 2'b00;
      sd_d      <= '0;
      cpu_dout  <= 8'hFF;
      wait_cnt  <= '0;
      arb_err   <= 1'b0;
    end else begin
      rd_d   <= cpu_rd;
      wr_d   <= cpu_wr;
      addr_d <= cpu_addr;

      // A fresh event beats the clear on the issue edge so it is served next.
      if (cpu_event) begin
        cpu_pend  <= 1'b1;
        pend_addr <= cpu_addr;
        pend_we   <= cpu_wr;
        pend_din  <= cpu_din;
      end else if (issue_cpu) begin
        cpu_pend <= 1'b0;
      end

      if (ld_wr && !ld_busy) begin
        ld_busy   <= 1'b1;
        hold_addr <= ld_addr;
        hold_data <= ld_data;
      end else if (done && (state == ST_LD)) begin
        ld_busy <= 1'b0;
      end
      if (ld_wr && ld_busy) ld_ovf <= 1'b1;

      if (issue_cpu) begin
        sd_req  <= ~sd_req;
        sd_addr <= pend_addr;
        sd_we   <= pend_we;
        sd_ds   <= pend_we ? {pend_addr[0], ~pend_addr[0]} : 2'b11;
        sd_d    <= {pend_din, pend_din};
      end else if (issue_ld) begin
        sd_req  <= ~sd_req;
        sd_addr <= hold_addr;
        sd_we   <= 1'b1;
        sd_ds   <= {hold_addr[0], ~hold_addr[0]};
        sd_d    <= {hold_data, hold_data};
      end

      if (cpu_rd && prot_hit) begin
        cpu_dout <= 8'h00;
      end else if (done && (state == ST_CPU) && !sd_we) begin
        cpu_dout <= sd_addr[0] ? sd_q[15:8] : sd_q[7:0];
      end

      // Diagnostic only: the transaction keeps waiting for its ack after the flag is raised.
      if (state == ST_IDLE) begin
        wait_cnt <= '0;
      end else if (!port_idle && (wait_cnt != CW'(TIMEOUT))) begin
        wait_cnt <= wait_cnt + CW'(1);
        if (wait_cnt == CW'(TIMEOUT - 1)) arb_err <= 1'b1;
      end
    end
  end

endmodule
